// File: rtl/fir_sample_sequencer_if.sv
// Sample-source, sample-RAM and MAC-side signals of the FIR sample sequencer.
// FIR_ZERO_FILL_EN adds tap_zero to the bundle.
interface fir_sample_sequencer_if #(
  parameter int unsigned taille_mot = 32
);
  logic                  s_valid;
  logic [taille_mot-1:0] s_data;
  logic                  s_ready;
  logic                  ram_wr;
  logic [7:0]            ram_waddr;
  logic [7:0]            ram_raddr;
  logic [taille_mot-1:0] ram_din;
  logic                  tap_valid;
  logic [7:0]            tap_idx;
  logic                  tap_first;
  logic                  tap_last;
  logic                  busy;
  logic                  done;
`ifdef FIR_ZERO_FILL_EN
  logic                  tap_zero;

  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_wr, ram_waddr, ram_raddr, ram_din,
    output tap_valid, tap_idx, tap_first, tap_last, busy, done, tap_zero
  );
  modport master (
    output s_valid, s_data,
    input  s_ready, ram_wr, ram_waddr, ram_raddr, ram_din,
    input  tap_valid, tap_idx, tap_first, tap_last, busy, done, tap_zero
  );
`else
  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_wr, ram_waddr, ram_raddr, ram_din,
    output tap_valid, tap_idx, tap_first, tap_last, busy, done
  );
  modport master (
    output s_valid, s_data,
    input  s_ready, ram_wr, ram_waddr, ram_raddr, ram_din,
    input  tap_valid, tap_idx, tap_first, tap_last, busy, done
  );
`endif
endinterface

// File: rtl/fir_sample_sequencer.sv
// FIR sample sequencer: writes each sample into a circular RAM, then reads nb_taps taps
// newest to oldest. Optional FIR_ZERO_FILL_EN flags taps not yet backed by real samples.
module fir_sample_sequencer #(
  parameter int unsigned taille_mem = 64,
  parameter int unsigned nb_taps    = 32,
  parameter int unsigned taille_mot = 32
) (
  input logic                   clk,
  input logic                   reset,
  fir_sample_sequencer_if.slave bus
);
  localparam int unsigned AddrW = $clog2(taille_mem);
  localparam logic [7:0]  LastK = 8'(nb_taps - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e                state_q, state_d;
  logic [AddrW-1:0]      wptr_q, wptr_d;
  logic [AddrW-1:0]      rd_next;
  logic [7:0]            k_q, k_d, k_next;
  logic                  ready_q, ready_d;
  logic                  wr_q, wr_d;
  logic                  tv_q, tv_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [7:0]            waddr_q, waddr_d;
  logic [7:0]            raddr_q, raddr_d;
  logic [7:0]            idx_q, idx_d;
  logic [taille_mot-1:0] din_q, din_d;
`ifdef FIR_ZERO_FILL_EN
  localparam logic [8:0] FillMax = 9'(nb_taps);
  logic [8:0]            fill_q, fill_d, fill_eff;
  logic                  zero_q, zero_d;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    k_d     = k_q;
    ready_d = 1'b0;
    wr_d    = 1'b0;
    tv_d    = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    idx_d   = idx_q;
    din_d   = din_q;
    k_next  = k_q + 8'd1;
    rd_next = wptr_q - k_next[AddrW-1:0];
`ifdef FIR_ZERO_FILL_EN
    fill_d   = fill_q;
    zero_d   = 1'b0;
    // Taps read during this sequence already see the sample just written.
    fill_eff = (fill_q < FillMax) ? fill_q + 9'd1 : fill_q;
`endif
    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (bus.s_valid && ready_q) begin
          ready_d = 1'b0;
          wr_d    = 1'b1;
          waddr_d = 8'(wptr_q);
          din_d   = bus.s_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        k_d     = 8'd0;
        raddr_d = 8'(wptr_q);
        state_d = StRead;
      end
      StRead: begin
        // Registered RAM read: the tap issued now is presented next cycle.
        tv_d    = 1'b1;
        idx_d   = k_q;
        first_d = (k_q == 8'd0);
        last_d  = (k_q == LastK);
`ifdef FIR_ZERO_FILL_EN
        zero_d  = ({1'b0, k_q} >= fill_eff);
`endif
        if (k_q == LastK) begin
          done_d  = 1'b1;
          state_d = StDrain;
        end else begin
          k_d     = k_next;
          raddr_d = 8'(rd_next);
        end
      end
      StDrain: begin
        wptr_d  = wptr_q + 1'b1;
        ready_d = 1'b1;
        state_d = StIdle;
`ifdef FIR_ZERO_FILL_EN
        if (fill_q < FillMax) fill_d = fill_q + 9'd1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      k_q     <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      tv_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      idx_q   <= '0;
      din_q   <= '0;
`ifdef FIR_ZERO_FILL_EN
      fill_q  <= '0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      tv_q    <= tv_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
`ifdef FIR_ZERO_FILL_EN
      fill_q  <= fill_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign bus.s_ready   = ready_q;
  assign bus.ram_wr    = wr_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_raddr = raddr_q;
  assign bus.ram_din   = din_q;
  assign bus.tap_valid = tv_q;
  assign bus.tap_idx   = idx_q;
  assign bus.tap_first = first_q;
  assign bus.tap_last  = last_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != StIdle);
`ifdef FIR_ZERO_FILL_EN
  assign bus.tap_zero  = zero_q;
`endif

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: scoreboarded main instance (8 words, 4 taps) plus a
// directed single-tap instance (2 words, 1 tap).
module tb_fir_sample_sequencer;
  localparam int unsigned Mem  = 8;
  localparam int unsigned Taps = 4;
  localparam int unsigned W    = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_sample_sequencer_if #(.taille_mot(W)) bus ();
  fir_sample_sequencer_if #(.taille_mot(W)) bus1 ();

  fir_sample_sequencer #(.taille_mem(Mem), .nb_taps(Taps), .taille_mot(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  fir_sample_sequencer #(.taille_mem(2), .nb_taps(1), .taille_mot(W)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  typedef struct {
    logic [7:0]   addr;
    logic [W-1:0] data;
  } exp_wr_t;

  typedef struct {
    int           idx;
    logic         first;
    logic         last;
    logic         done;
    logic         zero;
    logic [7:0]   addr;
    logic [W-1:0] data;
  } exp_tap_t;

  exp_wr_t      wq[$];
  exp_tap_t     tq[$];
  exp_wr_t      we;
  exp_tap_t     te;
  logic [W-1:0] hist [Mem];
  logic [W-1:0] ram [Mem];
  logic [W-1:0] ram_dout;
  logic [7:0]   prev_raddr;
  int           mw   = 0;
  int           fill = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample RAM behaviour: write has priority, registered read.
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_waddr[2:0]] <= bus.ram_din;
    else            ram_dout <= ram[bus.ram_raddr[2:0]];
  end

  function automatic void push_expect(input logic [W-1:0] d);
    exp_tap_t t;
    int eff;
    int a;
    wq.push_back('{addr: 8'(mw), data: d});
    hist[mw] = d;
    eff = (fill < Taps) ? fill + 1 : fill;
    for (int k = 0; k < Taps; k++) begin
      a       = (mw - k + Mem) % Mem;
      t.idx   = k;
      t.first = (k == 0);
      t.last  = (k == Taps - 1);
      t.done  = (k == Taps - 1);
      t.zero  = (k >= eff);
      t.addr  = 8'(a);
      t.data  = hist[a];
      tq.push_back(t);
    end
    mw = (mw + 1) % Mem;
    if (fill < Taps) fill++;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (bus.ram_wr) begin
        if (wq.size() == 0) check("wr_unexpected", bus.ram_wr, 1'b0);
        else begin
          we = wq.pop_front();
          check("ram_waddr", bus.ram_waddr, we.addr);
          check("ram_din", bus.ram_din, we.data);
        end
      end
      if (bus.tap_valid) begin
        if (tq.size() == 0) check("tap_unexpected", bus.tap_valid, 1'b0);
        else begin
          te = tq.pop_front();
          check("tap_idx", bus.tap_idx, te.idx);
          check("tap_first", bus.tap_first, te.first);
          check("tap_last", bus.tap_last, te.last);
          check("done", bus.done, te.done);
          check("ram_raddr", prev_raddr, te.addr);
          check("tap_data", ram_dout, te.data);
`ifdef FIR_ZERO_FILL_EN
          check("tap_zero", bus.tap_zero, te.zero);
`endif
        end
      end else begin
        check("done_no_tap", bus.done, 1'b0);
      end
    end
    prev_raddr = bus.ram_raddr;
  end

  task automatic send(input logic [W-1:0] d, output int waited);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    waited = n;
    check("s_ready_wait", bus.s_ready, 1'b1);
    push_expect(d);
    @(posedge clk);
    #1;
    check("s_ready_drop", bus.s_ready, 1'b0);
    check("busy", bus.busy, 1'b1);
  endtask

  task automatic wait_idle(output int waited);
    int n = 0;
    while (!bus.s_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    waited = n;
    check("idle_wait", bus.s_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    for (int i = 0; i < Mem; i++) begin
      ram[i]  = '0;
      hist[i] = '0;
    end
    ram_dout     = '0;
    reset        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus1.s_valid = 1'b0;
    bus1.s_data  = '0;

    // Reset state
    #1;
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_ram_wr", bus.ram_wr, 1'b0);
    check("rst_tap_valid", bus.tap_valid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_raddr", bus.ram_raddr, 8'd0);
    check("rst_waddr", bus.ram_waddr, 8'd0);
    check("rst_b_ready", bus1.s_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("ready_before_edge", bus.s_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_edge", bus.s_ready, 1'b1);

    // Single sample 0xA5: writes addr 0, reads 0,7,6,5, ready low Taps+2 cycles
    send(32'hA5, w);
    bus.s_valid = 1'b0;
    check("first_write", bus.ram_wr, 1'b1);
    wait_idle(n);
    check("ready_low_cycles", n, Taps + 2);
    check("tap_q_empty_1", tq.size(), 0);

    // Eight more: the ninth overall wraps to addr 0
    for (int i = 1; i <= 8; i++) begin
      send(32'h100 + i, w);
      bus.s_valid = 1'b0;
      wait_idle(n);
    end
    check("tap_q_empty_2", tq.size(), 0);

    // s_valid held high: one accept every Taps+3 cycles
    send(32'h2000, w);
    for (int i = 1; i <= 5; i++) begin
      send(32'h2000 + i, w);
      check("stream_gap", w, Taps + 2);
    end
    bus.s_valid = 1'b0;
    wait_idle(n);
    check("wr_q_empty", wq.size(), 0);

    // Reset during READ at k=2
    send(32'h77, w);
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_tap_valid", bus.tap_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_tap_valid", bus.tap_valid, 1'b0);
    check("mid_rst_ram_wr", bus.ram_wr, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    tq.delete();
    mw   = 0;
    fill = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Restart at addr 0; also exercises zero-fill start-up when enabled
    for (int i = 0; i < 5; i++) begin
      send(32'h300 + i, w);
      bus.s_valid = 1'b0;
      wait_idle(n);
    end
    check("tap_q_empty_3", tq.size(), 0);
    check("wr_q_empty_2", wq.size(), 0);

    // Single-tap instance: first = last = done on one tap, ready low 3 cycles
    for (int s = 0; s < 2; s++) begin
      bus1.s_valid = 1'b1;
      bus1.s_data  = 32'h3C + s;
      n = 0;
      while (!bus1.s_ready && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("b_ready_wait", bus1.s_ready, 1'b1);
      @(posedge clk);
      #1;
      bus1.s_valid = 1'b0;
      check("b_wr", bus1.ram_wr, 1'b1);
      check("b_waddr", bus1.ram_waddr, s);
      check("b_din", bus1.ram_din, 32'h3C + s);
      check("b_ready_low0", bus1.s_ready, 1'b0);
      @(posedge clk);
      #1;
      check("b_wr_off", bus1.ram_wr, 1'b0);
      check("b_raddr", bus1.ram_raddr, s);
      check("b_tv_pre", bus1.tap_valid, 1'b0);
      check("b_ready_low1", bus1.s_ready, 1'b0);
      @(posedge clk);
      #1;
      check("b_tap_valid", bus1.tap_valid, 1'b1);
      check("b_tap_idx", bus1.tap_idx, 8'd0);
      check("b_tap_first", bus1.tap_first, 1'b1);
      check("b_tap_last", bus1.tap_last, 1'b1);
      check("b_done", bus1.done, 1'b1);
      check("b_ready_low2", bus1.s_ready, 1'b0);
      @(posedge clk);
      #1;
      check("b_ready_back", bus1.s_ready, 1'b1);
      check("b_tv_off", bus1.tap_valid, 1'b0);
      check("b_done_off", bus1.done, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
